// File: rtl/sparc_ifu_thrsched.sv
// sparc_ifu_thrsched: four-thread DEAD/RDY/RUN/WAIT scheduler with LRU pick of the fetch thread.
// Optional per-thread WAIT watchdog is built when SPARC_THRSCHED_WDOG_EN is defined.
module sparc_ifu_thrsched #(
  parameter int NTHR = 4,
  parameter int TO_W = 10
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [NTHR-1:0] thr_activate,
  input  logic [NTHR-1:0] thr_halt,
  input  logic            sw_wait,
  input  logic            sw_yield,
  input  logic            stall,
  input  logic [NTHR-1:0] completion,
  output logic [NTHR-1:0] thr_f,
  output logic            run_valid,
  output logic [NTHR-1:0] thr_rdy,
  output logic [NTHR-1:0] thr_wait,
  output logic            all_wait,
  output logic [NTHR-1:0] wdog_err
);
  typedef enum logic [1:0] {DEAD = 2'b00, RDY = 2'b01, RUN = 2'b10, WAIT = 2'b11} st_t;
  st_t st [NTHR];
  st_t st_n [NTHR];
  logic [1:0] ord [NTHR];
  logic [1:0] ord_n [NTHR];
  logic [NTHR-1:0] run, rdy, wt, cand;
  logic [1:0] sel;
  logic found, leave, go;
  int pos;
  always_comb begin
    for (int i = 0; i < NTHR; i++) begin
      run[i] = st[i] == RUN;
      rdy[i] = st[i] == RDY;
      wt[i] = st[i] == WAIT;
    end
  end
  // Candidates are RDY before this edge; a thread halted this cycle cannot be picked.
  assign cand = rdy & ~thr_halt;
  assign leave = |(run & thr_halt) || sw_wait || (sw_yield && |cand);
  always_comb begin
    found = 1'b0;
    sel = '0;
    pos = 0;
    for (int p = NTHR - 1; p >= 0; p--)
      if (cand[ord[p]]) begin
        found = 1'b1;
        sel = ord[p];
        pos = p;
      end
  end
  assign go = !stall && (!(|run) || leave) && found;
  always_comb begin
    for (int p = 0; p < NTHR; p++)
      ord_n[p] = (!go || p < pos) ? ord[p] : (p == NTHR - 1) ? sel : ord[(p + 1) % NTHR];
  end
  always_comb begin
    for (int i = 0; i < NTHR; i++)
      st_n[i] = thr_halt[i] ? DEAD :
                st[i] == DEAD ? (thr_activate[i] ? RDY : DEAD) :
                st[i] == RUN  ? (sw_wait ? (completion[i] ? RDY : WAIT) : (sw_yield && |cand) ? RDY : RUN) :
                st[i] == WAIT ? (completion[i] ? RDY : WAIT) :
                (go && sel == 2'(i)) ? RUN : RDY;
  end
  always_ff @(posedge clk) begin
    if (!rst_l)
      for (int i = 0; i < NTHR; i++) begin
        st[i] <= DEAD;
        ord[i] <= 2'(i);
      end
    else begin
      st <= st_n;
      ord <= ord_n;
    end
  end
  assign thr_f = run;
  assign run_valid = |run;
  assign thr_rdy = rdy;
  assign thr_wait = wt;
  assign all_wait = !(|run) && !(|rdy) && |wt;
`ifdef SPARC_THRSCHED_WDOG_EN
  logic [TO_W-1:0] cnt [NTHR];
  logic [NTHR-1:0] err;
  always_ff @(posedge clk) begin
    if (!rst_l)
      for (int i = 0; i < NTHR; i++) begin
        cnt[i] <= '0;
        err[i] <= 1'b0;
      end
    else
      for (int i = 0; i < NTHR; i++)
        if (st[i] != WAIT || st_n[i] != WAIT) begin
          cnt[i] <= '0;
          err[i] <= 1'b0;
        end else if (!(&cnt[i])) begin
          cnt[i] <= cnt[i] + 1'b1;
          err[i] <= ~cnt[i] == TO_W'(1);
        end
  end
  assign wdog_err = err;
`else
  assign wdog_err = {NTHR{TO_W < 1}};
`endif
endmodule
